icache: RTL and testbench

Direct-mapped instruction cache between the IF stage and the memory controller's instruction port. A hit returns the instruction one cycle after the request. A miss issues a single word read to the memory controller, fills the line from the response, and returns the instruction. A flush from the pipeline cancels delivery of an outstanding miss without corrupting the controller handshake.

---
 rtl/icache_pkg.sv | 18 +
 rtl/icache_if.sv | 30 +++
 rtl/icache_array.sv | 46 ++++
 rtl/icache.sv | 134 +++++++++++++
 tb/tb_icache.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int INDEX_BITS_DEF = 6;
    localparam int ADDR_W_DEF     = 32;
    localparam int TAG_W_DEF      = ADDR_W_DEF - INDEX_BITS_DEF - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int tag_width(input int addr_w, input int index_bits);
        return addr_w - index_bits - 2;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
interface icache_if #(
    parameter int ADDR_W = icache_pkg::ADDR_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic [ADDR_W-1:0] if_resp_addr;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_resp_addr;
    logic [31:0]       mem_inst;

    // The cache itself
    modport slave (
        input  if_req, if_addr, flush, mem_valid, mem_resp_addr, mem_inst,
        output if_ready, if_valid, if_inst, if_resp_addr, mem_req, mem_addr
    );

    // The pipeline plus memory controller environment
    modport master (
        output if_req, if_addr, flush, mem_valid, mem_resp_addr, mem_inst,
        input  if_ready, if_valid, if_inst, if_resp_addr, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data store: combinational read, synchronous write, async valid clear.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_W      = TAG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    // Only the valid bits need clearing; stale tag/data are masked by them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with miss FSM and flush drain.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic    clk,
    input  logic    rst,
    icache_if.slave bus
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  miss_addr_reg, miss_addr_next;
    logic               if_valid_reg, if_valid_next;
    logic [31:0]        if_inst_reg, if_inst_next;
    logic [ADDR_W-1:0]  if_resp_addr_reg, if_resp_addr_next;

    logic [ADDR_W-1:0]  req_word;
    logic [INDEX_BITS-1:0] rd_index;
    logic [TAG_W-1:0]   req_tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_data;
    logic               hit;

    logic               wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic [TAG_W-1:0]   wr_tag;
    logic               resp_match;

    assign req_word = {bus.if_addr[ADDR_W-1:2], 2'b00};
    assign rd_index = req_word[INDEX_BITS+1:2];
    assign req_tag  = req_word[ADDR_W-1:INDEX_BITS+2];
    assign hit      = rd_valid && (rd_tag == req_tag);

    // miss_addr_reg is always word aligned, so it doubles as mem_addr.
    assign wr_index   = miss_addr_reg[INDEX_BITS+1:2];
    assign wr_tag     = miss_addr_reg[ADDR_W-1:INDEX_BITS+2];
    assign resp_match = bus.mem_valid && (bus.mem_resp_addr == miss_addr_reg);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (bus.mem_inst)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            miss_addr_reg    <= '0;
            if_valid_reg     <= 1'b0;
            if_inst_reg      <= '0;
            if_resp_addr_reg <= '0;
        end else begin
            state_reg        <= state_next;
            miss_addr_reg    <= miss_addr_next;
            if_valid_reg     <= if_valid_next;
            if_inst_reg      <= if_inst_next;
            if_resp_addr_reg <= if_resp_addr_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        miss_addr_next    = miss_addr_reg;
        if_valid_next     = 1'b0;
        if_inst_next      = if_inst_reg;
        if_resp_addr_next = if_resp_addr_reg;
        wr_en             = 1'b0;

        case (state_reg)
            IDLE: begin
                // Responses arriving here belong to nothing we still track.
                if (bus.if_req && !bus.flush) begin
                    if (hit) begin
                        if_valid_next     = 1'b1;
                        if_inst_next      = rd_data;
                        if_resp_addr_next = req_word;
                    end else begin
                        miss_addr_next = req_word;
                        state_next     = MISS;
                    end
                end
            end

            MISS: begin
                if (resp_match) begin
                    wr_en      = 1'b1;
                    state_next = IDLE;
                    if (!bus.flush) begin
                        if_valid_next     = 1'b1;
                        if_inst_next      = bus.mem_inst;
                        if_resp_addr_next = miss_addr_reg;
                    end
                end else if (bus.flush) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                // The read is still in flight; absorb it so the controller stays in step.
                if (resp_match) begin
                    wr_en      = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.if_ready     = (state_reg == IDLE);
    assign bus.if_valid     = if_valid_reg;
    assign bus.if_inst      = if_inst_reg;
    assign bus.if_resp_addr = if_resp_addr_reg;
    assign bus.mem_req      = (state_reg == MISS) && !bus.mem_valid;
    assign bus.mem_addr     = miss_addr_reg;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches against a line-level model.
module tb_icache;
    import icache_pkg::*;

    localparam int AW    = ADDR_W_DEF;
    localparam int IB    = INDEX_BITS_DEF;
    localparam int LINES = 1 << IB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    icache_if #(.ADDR_W(AW)) bus ();

    icache #(.INDEX_BITS(IB), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each line remembers which word address it holds.
    bit          m_valid [LINES];
    logic [31:0] m_word  [LINES];
    logic [31:0] m_data  [LINES];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % LINES);
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // Memory contents seen through the controller.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return word_of(a) | 32'h3;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_word[idx_of(a)] == word_of(a));
    endfunction

    task automatic model_fill(input logic [31:0] a);
        m_valid[idx_of(a)] = 1'b1;
        m_word[idx_of(a)]  = word_of(a);
        m_data[idx_of(a)]  = mem_word(a);
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.if_req        = 1'b0;
        bus.if_addr       = '0;
        bus.flush         = 1'b0;
        bus.mem_valid     = 1'b0;
        bus.mem_resp_addr = '0;
        bus.mem_inst      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one fetch, services a miss after lat cycles of mem_req, reports observations.
    task automatic fetch(input logic [31:0] addr, input int lat, output bit was_hit,
                         output logic v, output logic [31:0] inst, output logic [31:0] raddr,
                         output int proto_err);
        logic [31:0] word;
        word      = word_of(addr);
        proto_err = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        tick();
        bus.if_req  = 1'b0;
        bus.if_addr = $urandom;
        @(negedge clk);
        if (bus.if_valid === 1'b1) begin
            was_hit = 1'b1;
            v       = bus.if_valid;
            inst    = bus.if_inst;
            raddr   = bus.if_resp_addr;
            if (bus.mem_req !== 1'b0 || bus.if_ready !== 1'b1) proto_err++;
        end else begin
            was_hit = 1'b0;
            for (int i = 0; i < lat; i++) begin
                if (i > 0) @(negedge clk);
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== word ||
                    bus.if_ready !== 1'b0 || bus.if_valid !== 1'b0) proto_err++;
                tick();
            end
            bus.mem_valid     = 1'b1;
            bus.mem_resp_addr = word;
            bus.mem_inst      = mem_word(word);
            @(negedge clk);
            if (bus.mem_req !== 1'b0) proto_err++;
            tick();
            bus.mem_valid     = 1'b0;
            bus.mem_resp_addr = $urandom;
            bus.mem_inst      = $urandom;
            @(negedge clk);
            v     = bus.if_valid;
            inst  = bus.if_inst;
            raddr = bus.if_resp_addr;
            if (bus.if_ready !== 1'b1) proto_err++;
        end
        tick();
        $display("fetch addr=%08h hit=%0d valid=%0d inst=%08h resp_addr=%08h proto_err=%0d",
                 addr, was_hit, v, inst, raddr, proto_err);
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid got=%0b exp=0", bus.if_valid); end
        vectors++; if (bus.if_inst !== 32'h0) begin miscompares++; $display("FAIL reset_if_inst got=%08h exp=0", bus.if_inst); end
        vectors++; if (bus.if_resp_addr !== 32'h0) begin miscompares++; $display("FAIL reset_resp_addr got=%08h exp=0", bus.if_resp_addr); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req); end
        vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got=%08h exp=0", bus.mem_addr); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL reset_if_ready got=%0b exp=1", bus.if_ready); end
        model_clear();
        tick();
    endtask

    task automatic test_cold_miss();
        bit h; logic v; logic [31:0] inst, raddr; int pe;
        fetch(32'h10, 6, h, v, inst, raddr, pe);
        vectors++; if (h !== 1'b0) begin miscompares++; $display("FAIL cold_is_miss got=%0b exp=0", h); end
        vectors++; if (pe != 0) begin miscompares++; $display("FAIL cold_protocol got=%0d errors exp=0", pe); end
        vectors++; if (v !== 1'b1 || inst !== 32'h13 || raddr !== 32'h10) begin
            miscompares++; $display("FAIL cold_deliver got v=%0b inst=%08h addr=%08h exp v=1 inst=00000013 addr=00000010", v, inst, raddr);
        end
        @(negedge clk);
        vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL cold_pulse_width got=%0b exp=0", bus.if_valid); end
        model_fill(32'h10);
        tick();
    endtask

    task automatic test_hit();
        bit h; logic v; logic [31:0] inst, raddr; int pe;
        fetch(32'h12, 1, h, v, inst, raddr, pe);
        vectors++; if (h !== 1'b1 || pe != 0) begin miscompares++; $display("FAIL hit_timing got hit=%0b proto_err=%0d exp hit=1 proto_err=0", h, pe); end
        vectors++; if (inst !== 32'h13 || raddr !== 32'h10) begin
            miscompares++; $display("FAIL hit_data got inst=%08h addr=%08h exp inst=00000013 addr=00000010", inst, raddr);
        end
    endtask

    task automatic test_conflict();
        bit h; logic v; logic [31:0] inst, raddr; int pe;
        fetch(32'h110, 3, h, v, inst, raddr, pe);
        vectors++; if (h !== 1'b0 || pe != 0 || inst !== 32'h113 || raddr !== 32'h110) begin
            miscompares++; $display("FAIL conflict_fill got hit=%0b pe=%0d inst=%08h addr=%08h exp hit=0 pe=0 inst=00000113 addr=00000110", h, pe, inst, raddr);
        end
        model_fill(32'h110);
        fetch(32'h10, 2, h, v, inst, raddr, pe);
        vectors++; if (h !== model_hit(32'h10) || inst !== 32'h13) begin
            miscompares++; $display("FAIL conflict_evict got hit=%0b inst=%08h exp hit=0 inst=00000013", h, inst);
        end
        model_fill(32'h10);
    endtask

    task automatic test_flush_miss();
        bit h; logic v; logic [31:0] inst, raddr; int pe;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        tick();
        bus.if_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL flush_miss_req_start got=%0b exp=1", bus.mem_req); end
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b0 || bus.if_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_miss_drain got mem_req=%0b if_ready=%0b exp 0 0", bus.mem_req, bus.if_ready);
        end
        tick(); tick();
        bus.mem_valid = 1'b1; bus.mem_resp_addr = 32'h20; bus.mem_inst = mem_word(32'h20);
        tick();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.if_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_miss_suppress got if_valid=%0b if_ready=%0b exp 0 1", bus.if_valid, bus.if_ready);
        end
        model_fill(32'h20);
        tick();
        fetch(32'h20, 1, h, v, inst, raddr, pe);
        vectors++; if (h !== 1'b1 || inst !== 32'h23) begin
            miscompares++; $display("FAIL flush_miss_refetch got hit=%0b inst=%08h exp hit=1 inst=00000023", h, inst);
        end
    endtask

    task automatic test_flush_same_cycle();
        bit h; logic v; logic [31:0] inst, raddr; int pe;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        tick();
        bus.if_req = 1'b0;
        bus.flush = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_resp_addr = 32'h30; bus.mem_inst = mem_word(32'h30);
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL flush_resp_mem_req got=%0b exp=0", bus.mem_req); end
        tick();
        bus.flush = 1'b0; bus.mem_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.if_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_resp_suppress got if_valid=%0b if_ready=%0b exp 0 1", bus.if_valid, bus.if_ready);
        end
        model_fill(32'h30);
        tick();
        fetch(32'h31, 1, h, v, inst, raddr, pe);
        vectors++; if (h !== 1'b1 || inst !== 32'h33 || raddr !== 32'h30) begin
            miscompares++; $display("FAIL flush_resp_refetch got hit=%0b inst=%08h addr=%08h exp hit=1 inst=00000033 addr=00000030", h, inst, raddr);
        end
    endtask

    task automatic test_flush_idle();
        bus.if_req = 1'b1; bus.if_addr = 32'h50; bus.flush = 1'b1;
        tick();
        bus.if_req = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        vectors++; if (bus.if_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_idle_drop got ready=%0b mem_req=%0b valid=%0b exp 1 0 0", bus.if_ready, bus.mem_req, bus.if_valid);
        end
        tick();
    endtask

    task automatic test_stale_response();
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        tick();
        bus.if_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
            miscompares++; $display("FAIL stale_req got mem_req=%0b addr=%08h exp 1 00000040", bus.mem_req, bus.mem_addr);
        end
        tick();
        bus.mem_valid = 1'b1; bus.mem_resp_addr = 32'h44; bus.mem_inst = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL stale_resp_cycle_req got=%0b exp=0", bus.mem_req); end
        tick();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b1 || bus.if_ready !== 1'b0 || bus.if_valid !== 1'b0) begin
            miscompares++; $display("FAIL stale_ignored got mem_req=%0b ready=%0b valid=%0b exp 1 0 0", bus.mem_req, bus.if_ready, bus.if_valid);
        end
        tick();
        bus.mem_valid = 1'b1; bus.mem_resp_addr = 32'h40; bus.mem_inst = mem_word(32'h40);
        tick();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h43 || bus.if_resp_addr !== 32'h40) begin
            miscompares++; $display("FAIL stale_then_match got valid=%0b inst=%08h addr=%08h exp 1 00000043 00000040", bus.if_valid, bus.if_inst, bus.if_resp_addr);
        end
        model_fill(32'h40);
        tick();
    endtask

    task automatic test_idle_response();
        bit h; logic v; logic [31:0] inst, raddr; int pe;
        bus.mem_valid = 1'b1; bus.mem_resp_addr = 32'h60; bus.mem_inst = 32'h1234_5678;
        tick();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.if_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
            miscompares++; $display("FAIL idle_resp_ignored got valid=%0b ready=%0b exp 0 1", bus.if_valid, bus.if_ready);
        end
        tick();
        fetch(32'h60, 2, h, v, inst, raddr, pe);
        vectors++; if (h !== model_hit(32'h60) || inst !== 32'h63) begin
            miscompares++; $display("FAIL idle_resp_no_fill got hit=%0b inst=%08h exp hit=0 inst=00000063", h, inst);
        end
        model_fill(32'h60);
    endtask

    task automatic test_random(input int n);
        logic [31:0] pool [12];
        bit h; logic v; logic [31:0] inst, raddr; int pe;
        bit exp_hit; logic [31:0] exp_inst;
        // Few indexes, many tags: forces evictions as well as repeat hits.
        for (int i = 0; i < 12; i++)
            pool[i] = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 11)];
            exp_hit  = model_hit(a);
            exp_inst = exp_hit ? m_data[idx_of(a)] : mem_word(a);
            fetch(a, $urandom_range(1, 4), h, v, inst, raddr, pe);
            vectors++;
            if (h !== exp_hit || v !== 1'b1 || inst !== exp_inst || raddr !== word_of(a) || pe != 0) begin
                miscompares++;
                $display("FAIL random_fetch addr=%08h got hit=%0b v=%0b inst=%08h raddr=%08h pe=%0d exp hit=%0b v=1 inst=%08h raddr=%08h pe=0",
                         a, h, v, inst, raddr, pe, exp_hit, exp_inst, word_of(a));
            end
            if (!exp_hit) model_fill(a);
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [31:0] q [$];
        logic [31:0] prev;
        for (int i = 0; i < LINES; i++)
            if (m_valid[i]) q.push_back(m_word[i] | 32'($urandom_range(0, 3)));
        prev = '0;
        for (int k = 0; k <= n; k++) begin
            logic [31:0] a;
            a = q[$urandom_range(0, q.size() - 1)];
            bus.if_req  = (k < n);
            bus.if_addr = a;
            @(negedge clk);
            if (k > 0) begin
                vectors++;
                if (bus.if_valid !== 1'b1 || bus.if_inst !== m_data[idx_of(prev)] ||
                    bus.if_resp_addr !== word_of(prev) || bus.mem_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL back_to_back addr=%08h got v=%0b inst=%08h raddr=%08h mem_req=%0b exp v=1 inst=%08h raddr=%08h mem_req=0",
                             prev, bus.if_valid, bus.if_inst, bus.if_resp_addr, bus.mem_req, m_data[idx_of(prev)], word_of(prev));
                end
            end
            prev = a;
            tick();
        end
        bus.if_req = 1'b0;
    endtask

    task automatic test_async_reset();
        bit h; logic v; logic [31:0] inst, raddr; int pe;
        bus.if_req = 1'b1; bus.if_addr = 32'h70;
        tick();
        bus.if_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL areset_pre_req got=%0b exp=1", bus.mem_req); end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.if_valid !== 1'b0 ||
            bus.if_inst !== 32'h0 || bus.if_resp_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_immediate got mem_req=%0b mem_addr=%08h valid=%0b inst=%08h raddr=%08h exp all 0",
                     bus.mem_req, bus.mem_addr, bus.if_valid, bus.if_inst, bus.if_resp_addr);
        end
        model_clear();
        tick();
        rst = 1'b1;
        tick();
        bus.mem_valid = 1'b1; bus.mem_resp_addr = 32'h70; bus.mem_inst = mem_word(32'h70);
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL areset_late_req got=%0b exp=0", bus.mem_req); end
        tick();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.if_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
            miscompares++; $display("FAIL areset_late_resp got valid=%0b ready=%0b exp 0 1", bus.if_valid, bus.if_ready);
        end
        tick();
        fetch(32'h10, 2, h, v, inst, raddr, pe);
        vectors++; if (h !== model_hit(32'h10) || inst !== 32'h13) begin
            miscompares++; $display("FAIL areset_lines_invalid got hit=%0b inst=%08h exp hit=0 inst=00000013", h, inst);
        end
        model_fill(32'h10);
        fetch(32'h70, 1, h, v, inst, raddr, pe);
        vectors++; if (h !== model_hit(32'h70) || inst !== 32'h73) begin
            miscompares++; $display("FAIL areset_no_late_fill got hit=%0b inst=%08h exp hit=0 inst=00000073", h, inst);
        end
        model_fill(32'h70);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_miss();
        test_flush_same_cycle();
        test_flush_idle();
        test_stale_response();
        test_idle_response();
        test_random(40);
        test_back_to_back(16);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
